// File: rtl/led_matrix_pkg.sv
// ============================================================================
//  led_matrix_pkg
//  Shared types and constants for the 8x8 LED matrix serial output path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package led_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_PIXELS = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam int START_BITS    = 32;
    localparam int LED_WORD_BITS = 32;
    localparam int NUM_LEDS      = 64;

    localparam logic [31:0] COLOUR_FG_DEF = 32'hf0000f00;
    localparam logic [31:0] COLOUR_BG_DEF = 32'hf0070000;

endpackage

`default_nettype wire

// File: rtl/led_frame_serializer_if.sv
// ============================================================================
//  led_frame_serializer_if
//  Upstream frame handshake: bitmap plus foreground/background colour words.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface led_frame_serializer_if;
    import led_matrix_pkg::*;

    logic                frame_valid;
    logic                frame_ready;
    logic [NUM_LEDS-1:0] frame_bitmap;
    logic [31:0]         fg_colour;
    logic [31:0]         bg_colour;

    modport master (
        output frame_valid,
        output frame_bitmap,
        output fg_colour,
        output bg_colour,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_bitmap,
        input  fg_colour,
        input  bg_colour,
        output frame_ready
    );

endinterface

`default_nettype wire

// File: rtl/led_bit_timer.sv
// ============================================================================
//  led_bit_timer
//  CLK_DIV divider producing led_clk, a data-load strobe and a bit-done strobe.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module led_bit_timer #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic start,
    output logic led_clk,
    output logic load,
    output logic bit_done
);

    localparam int              CW         = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   c_DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_led_clk;
    logic          w_tick;

    assign w_tick = run && (r_div_cnt == c_DIV_LAST);

    // start clears the divider so the first half-period is always full length
    always_ff @(posedge clk) begin
        if (reset || start || !run) begin
            r_div_cnt <= '0;
            r_led_clk <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_led_clk <= ~r_led_clk;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    assign led_clk  = r_led_clk;
    assign bit_done = w_tick & r_led_clk;
    assign load     = start | bit_done;

endmodule

`default_nettype wire

// File: rtl/led_frame_serializer.sv
// ============================================================================
//  led_frame_serializer
//  Emits one APA102-style frame (start, 64 LED words, end padding) per bitmap.
//  Optional macro LED_SERPENTINE_EN selects snake-wired matrix addressing.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module led_frame_serializer
    import led_matrix_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int END_BITS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    led_frame_serializer_if.slave  frame_if,
    output logic                   led_clk,
    output logic                   led_data,
    output logic                   busy
);

    localparam int         END_WORDS    = END_BITS / LED_WORD_BITS;
    localparam logic [4:0] c_WORD_LAST  = 5'(LED_WORD_BITS - 1);
    localparam logic [4:0] c_START_LAST = 5'(START_BITS - 1);
    localparam logic [5:0] c_LED_LAST   = 6'(NUM_LEDS - 1);
    localparam logic [5:0] c_END_LAST   = (END_WORDS > 0) ? 6'(END_WORDS - 1) : 6'd0;

    state_t        r_state;
    logic [4:0]    r_bit_cnt;
    logic [5:0]    r_led_cnt;
    logic [63:0]   r_bitmap;
    logic [31:0]   r_fg;
    logic [31:0]   r_bg;
    logic          r_ready;
    logic          r_busy;
    logic          r_led_data;

    logic          w_accept;
    logic          w_load;
    logic          w_bit_done;
    logic          w_word_end;
    logic [4:0]    w_bit_next;
    logic [4:0]    w_bit_idx;
    logic [5:0]    w_led_sel;
    logic [5:0]    w_src;
    logic [31:0]   w_word;
    logic          w_next_data;

    assign w_accept   = frame_if.frame_valid & r_ready;
    assign w_word_end = (r_bit_cnt == c_WORD_LAST);
    assign w_bit_next = r_bit_cnt + 5'd1;
    // words go out MSB first, so bit n of the word stream is word[31-n]
    assign w_bit_idx  = ~w_bit_next;
    assign w_led_sel  = (r_state == ST_PIXELS && w_word_end) ? r_led_cnt + 6'd1 : r_led_cnt;

`ifdef LED_SERPENTINE_EN
    assign w_src = w_led_sel[3] ? w_led_sel : {w_led_sel[5:3], ~w_led_sel[2:0]};
`else
    assign w_src = w_led_sel;
`endif

    assign w_word = r_bitmap[w_src] ? r_fg : r_bg;

    always_comb begin
        w_next_data = 1'b0;
        case (r_state)
            ST_START:  if (r_bit_cnt == c_START_LAST)               w_next_data = w_word[w_bit_idx];
            ST_PIXELS: if (!(w_word_end && r_led_cnt == c_LED_LAST)) w_next_data = w_word[w_bit_idx];
            default:   w_next_data = 1'b0;
        endcase
    end

    led_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (r_busy),
        .start    (w_accept),
        .led_clk  (led_clk),
        .load     (w_load),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bitmap <= frame_if.frame_bitmap;
            r_fg     <= frame_if.fg_colour;
            r_bg     <= frame_if.bg_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       r_led_data <= 1'b0;
        else if (w_load) r_led_data <= w_next_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= 5'd0;
            r_led_cnt <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 5'd0;
                        r_led_cnt <= 6'd0;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= w_bit_next;
                        if (r_bit_cnt == c_START_LAST) r_state <= ST_PIXELS;
                    end
                end
                ST_PIXELS: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= w_bit_next;
                        if (w_word_end) begin
                            if (r_led_cnt == c_LED_LAST) begin
                                r_led_cnt <= 6'd0;
                                if (END_WORDS == 0) begin
                                    r_state <= ST_IDLE;
                                    r_ready <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= ST_END;
                                end
                            end else begin
                                r_led_cnt <= r_led_cnt + 6'd1;
                            end
                        end
                    end
                end
                ST_END: begin
                    // led_cnt is reused here to count padding words
                    if (w_bit_done) begin
                        r_bit_cnt <= w_bit_next;
                        if (w_word_end) begin
                            if (r_led_cnt == c_END_LAST) begin
                                r_state   <= ST_IDLE;
                                r_ready   <= 1'b1;
                                r_busy    <= 1'b0;
                                r_led_cnt <= 6'd0;
                            end else begin
                                r_led_cnt <= r_led_cnt + 6'd1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign frame_if.frame_ready = r_ready;
    assign busy                 = r_busy;
    assign led_data             = r_led_data;

endmodule

`default_nettype wire
